// File: rtl/safety_interlock_if.sv
// ----------------------------------------------------------------------------
// safety_interlock_if
//   Bundles the limit-checker fail lines, host controls and interlock status
//   outputs that connect to safety_interlock. Clock and reset are not part of
//   the bundle. They stay as plain ports on the design.
//
//   Parameter
//     CNT_W   width of each per-source fault counter (must match the design)
//
//   Signals (direction given from the interlock's point of view)
//     pulse_lower_limit_fail  in     width-below-limit fail from checker
//     pulse_upper_limit_fail  in     width-above-limit fail from checker
//     rate_lower_limit_fail   in     rate-below-limit fail from checker
//     laser_ready             in     laser driver ready
//     arm                     in     level: host requests laser enable
//     clear_req               in     pulse: host requests fault clear
//     cnt_clr                 in     pulse: zero all fault counters
//     laser_enable            out    registered enable to laser gate
//     fault_latched           out    high in FAULT, CLEARING, HOLDOFF
//     fault_src               out    {rate_low, width_high, width_low} at trip
//     clear_fail              out    clear strobe to limit checker
//     state_o                 out    FSM state for status readback
//     cnt_width_low           out    width-low fault count
//     cnt_width_high          out    width-high fault count
//     cnt_rate_low            out    rate-low fault count
//
//   Modports
//     master  host / checker side (drives the inputs)
//     slave   the interlock itself
// ----------------------------------------------------------------------------
interface safety_interlock_if #(
  parameter int unsigned CNT_W = 16
);
  logic             pulse_lower_limit_fail;
  logic             pulse_upper_limit_fail;
  logic             rate_lower_limit_fail;
  logic             laser_ready;
  logic             arm;
  logic             clear_req;
  logic             cnt_clr;
  logic             laser_enable;
  logic             fault_latched;
  logic [2:0]       fault_src;
  logic             clear_fail;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cnt_width_low;
  logic [CNT_W-1:0] cnt_width_high;
  logic [CNT_W-1:0] cnt_rate_low;

  modport master (
    output pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail,
    output laser_ready, arm, clear_req, cnt_clr,
    input  laser_enable, fault_latched, fault_src, clear_fail, state_o,
    input  cnt_width_low, cnt_width_high, cnt_rate_low
  );

  modport slave (
    input  pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail,
    input  laser_ready, arm, clear_req, cnt_clr,
    output laser_enable, fault_latched, fault_src, clear_fail, state_o,
    output cnt_width_low, cnt_width_high, cnt_rate_low
  );
endinterface

// File: rtl/safety_interlock.sv
// ----------------------------------------------------------------------------
// safety_interlock
//   Downstream consumer of the pulse-width/rate limit checker. Any limit fail
//   while armed latches a sticky fault and drops the laser enable. The block
//   records which sources tripped and counts rising edges per source. Recovery
//   is sequenced as follows. A host clear_req drives the checker's clear_fail
//   for CLEAR_CYCLES cycles. The block then waits in HOLDOFF until
//   HOLDOFF_CYCLES consecutive quiet cycles have passed, and only then
//   returns to IDLE.
//
//   Parameters
//     CLEAR_CYCLES    cycles clear_fail is held high in CLEARING (>=1)
//     HOLDOFF_CYCLES  quiet cycles required in HOLDOFF before IDLE (>=1)
//     CNT_W           width of each per-source fault counter
//
//   Ports
//     clk   in  system clock
//     rst   in  synchronous reset, active-high, overrides everything
//     bus   safety_interlock_if.slave: fail inputs, host controls, status
//
//   Build option
//     FAULT_DEBOUNCE_EN  when defined, each fail input must be high for two
//                        consecutive cycles before it is honoured. Trip
//                        latency becomes N+2, and the counters count edges of
//                        the filtered signal. When undefined, the raw inputs
//                        are used and a trip takes effect at N+1.
// ----------------------------------------------------------------------------
module safety_interlock #(
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned HOLDOFF_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  safety_interlock_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_FAULT    = 3'd2,
    S_CLEARING = 3'd3,
    S_HOLDOFF  = 3'd4
  } state_t;

  // A single down-counter serves both the CLEARING window and the HOLDOFF
  // quiet period. The two never overlap.
  localparam int unsigned TMR_MAX = (HOLDOFF_CYCLES > CLEAR_CYCLES) ? HOLDOFF_CYCLES
                                                                    : CLEAR_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] CLEAR_LOAD   = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLDOFF_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Fail inputs, ordered {rate_low, width_high, width_low} to match fault_src.
  // --------------------------------------------------------------------------
  logic [2:0] fail_raw;
  logic [2:0] fail_vec;
  logic       fail_any;

  assign fail_raw = {bus.rate_lower_limit_fail,
                     bus.pulse_upper_limit_fail,
                     bus.pulse_lower_limit_fail};

`ifdef FAULT_DEBOUNCE_EN
  // Two-flop agreement: the current sample and the previous sample must both
  // be high before the input is treated as a fail.
  logic [2:0] fail_raw_q;

  always_ff @(posedge clk) begin
    if (rst) fail_raw_q <= '0;
    else     fail_raw_q <= fail_raw;
  end

  assign fail_vec = fail_raw & fail_raw_q;
`else
  assign fail_vec = fail_raw;
`endif

  assign fail_any = |fail_vec;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  state_t           state, state_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic [2:0]       src, src_next;

  // NOTE: every variable assigned in this block is given a default first, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    src_next   = src;

    case (state)
      S_IDLE: begin
        if (bus.arm && bus.laser_ready && !fail_any) state_next = S_ARMED;
      end

      S_ARMED: begin
        // A fail takes priority over a disarm. Every source that is high in
        // the same cycle is captured.
        if (fail_any) begin
          state_next = S_FAULT;
          src_next   = fail_vec;
        end else if (!bus.arm || !bus.laser_ready) begin
          state_next = S_IDLE;
        end
      end

      S_FAULT: begin
        if (bus.clear_req) begin
          state_next = S_CLEARING;
          tmr_next   = CLEAR_LOAD;
        end
      end

      S_CLEARING: begin
        if (tmr == '0) begin
          state_next = S_HOLDOFF;
          tmr_next   = HOLDOFF_LOAD;
        end else begin
          tmr_next = tmr - 1'b1;
        end
      end

      S_HOLDOFF: begin
        // Any fail restarts the quiet period from the beginning.
        if (fail_any) begin
          tmr_next = HOLDOFF_LOAD;
        end else if (tmr == '0) begin
          state_next = S_IDLE;
          src_next   = '0;
        end else begin
          tmr_next = tmr - 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  logic laser_enable_q;
  logic fault_latched_q;
  logic clear_fail_q;

  // NOTE: state is updated with non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      tmr             <= '0;
      src             <= '0;
      laser_enable_q  <= 1'b0;
      fault_latched_q <= 1'b0;
      clear_fail_q    <= 1'b0;
    end else begin
      state           <= state_next;
      tmr             <= tmr_next;
      src             <= src_next;
      // Outputs are decoded from the next state, so they are glitch-free
      // flops that line up with state_o in the same cycle.
      laser_enable_q  <= (state_next == S_ARMED);
      fault_latched_q <= (state_next == S_FAULT)    ||
                         (state_next == S_CLEARING) ||
                         (state_next == S_HOLDOFF);
      clear_fail_q    <= (state_next == S_CLEARING);
    end
  end

  // --------------------------------------------------------------------------
  // Per-source rising-edge counters. They are active in every state and
  // saturate at CNT_MAX. cnt_clr takes precedence over a coincident edge.
  // --------------------------------------------------------------------------
  logic [2:0]       fail_prev;
  logic [2:0]       fail_rise;
  logic [CNT_W-1:0] cnt [3];

  assign fail_rise = fail_vec & ~fail_prev;

  // NOTE: the counter array is only three registers wide and is visible
  // status, so it is reset explicitly. It is not left to power-up values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_prev <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      fail_prev <= fail_vec;
      for (int i = 0; i < 3; i++) begin
        if (bus.cnt_clr)                             cnt[i] <= '0;
        else if (fail_rise[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.laser_enable   = laser_enable_q;
  assign bus.fault_latched  = fault_latched_q;
  assign bus.fault_src      = src;
  assign bus.clear_fail     = clear_fail_q;
  assign bus.state_o        = state;
  assign bus.cnt_width_low  = cnt[0];
  assign bus.cnt_width_high = cnt[1];
  assign bus.cnt_rate_low   = cnt[2];

endmodule

// File: tb/tb_safety_interlock.sv
// ----------------------------------------------------------------------------
// tb_safety_interlock
//   Self-checking bench for safety_interlock in the default build (no fail
//   debounce). The bench applies directed scenarios first and then randomized
//   traffic. After every clock edge, all outputs are compared against a
//   behavioural model. That model counts CLEARING cycles and HOLDOFF quiet
//   cycles upward and tracks fault counts as plain integers.
// ----------------------------------------------------------------------------
module tb_safety_interlock;

  localparam int CLEAR_CYCLES   = 4;
  localparam int HOLDOFF_CYCLES = 8;
  localparam int CNT_W          = 2;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  safety_interlock_if #(.CNT_W(CNT_W)) bus ();

  safety_interlock #(
    .CLEAR_CYCLES  (CLEAR_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ARMED = 1, M_FAULT = 2, M_CLEARING = 3, M_HOLDOFF = 4;

  int         m_mode;
  int         m_clear_done;   // CLEARING cycles already spent
  int         m_quiet;        // consecutive quiet cycles seen in HOLDOFF
  logic [2:0] m_src;
  logic [2:0] m_prev;
  int         m_cnt [3];

  task automatic model_clock();
    logic [2:0] f;
    logic       any;
    f   = {bus.rate_lower_limit_fail, bus.pulse_upper_limit_fail, bus.pulse_lower_limit_fail};
    any = (f != 3'b000);
    if (rst) begin
      m_mode = M_IDLE; m_clear_done = 0; m_quiet = 0; m_src = 3'b000; m_prev = 3'b000;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.cnt_clr)                             m_cnt[i] = 0;
      else if (f[i] && !m_prev[i] && m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
    end
    m_prev = f;
    case (m_mode)
      M_IDLE:  if (bus.arm && bus.laser_ready && !any) m_mode = M_ARMED;
      M_ARMED: begin
        if (any) begin m_mode = M_FAULT; m_src = f; end
        else if (!bus.arm || !bus.laser_ready) m_mode = M_IDLE;
      end
      M_FAULT: if (bus.clear_req) begin m_mode = M_CLEARING; m_clear_done = 0; end
      M_CLEARING: begin
        m_clear_done = m_clear_done + 1;
        if (m_clear_done == CLEAR_CYCLES) begin m_mode = M_HOLDOFF; m_quiet = 0; end
      end
      M_HOLDOFF: begin
        m_quiet = any ? 0 : m_quiet + 1;
        if (m_quiet == HOLDOFF_CYCLES) begin m_mode = M_IDLE; m_src = 3'b000; end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic compare_model();
    check("laser_enable",   32'(bus.laser_enable),   32'(m_mode == M_ARMED));
    check("fault_latched",  32'(bus.fault_latched),
          32'(m_mode == M_FAULT || m_mode == M_CLEARING || m_mode == M_HOLDOFF));
    check("clear_fail",     32'(bus.clear_fail),     32'(m_mode == M_CLEARING));
    check("state_o",        32'(bus.state_o),        32'(m_mode));
    check("fault_src",      32'(bus.fault_src),      32'(m_src));
    check("cnt_width_low",  32'(bus.cnt_width_low),  32'(m_cnt[0]));
    check("cnt_width_high", 32'(bus.cnt_width_high), 32'(m_cnt[1]));
    check("cnt_rate_low",   32'(bus.cnt_rate_low),   32'(m_cnt[2]));
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_model();
  endtask

  task automatic set_fails(input logic rl, input logic wh, input logic wl);
    bus.rate_lower_limit_fail  = rl;
    bus.pulse_upper_limit_fail = wh;
    bus.pulse_lower_limit_fail = wl;
  endtask

  initial begin
    set_fails(1'b0, 1'b0, 1'b0);
    bus.laser_ready = 1'b0;
    bus.arm         = 1'b0;
    bus.clear_req   = 1'b0;
    bus.cnt_clr     = 1'b0;

    // Reset state
    rst = 1'b1;
    step(); step();
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_enable", 32'(bus.laser_enable), 32'd0);
    rst = 1'b0;

    // Arm: ARMED after one cycle
    bus.arm = 1'b1; bus.laser_ready = 1'b1;
    step();
    check("arm_state", 32'(bus.state_o), 32'd1);
    check("arm_enable", 32'(bus.laser_enable), 32'd1);

    // Single-cycle rate fail trips at N+1 and stays sticky with arm high
    set_fails(1'b1, 1'b0, 1'b0);
    step();
    set_fails(1'b0, 1'b0, 1'b0);
    check("trip_enable", 32'(bus.laser_enable), 32'd0);
    check("trip_latched", 32'(bus.fault_latched), 32'd1);
    check("trip_src", 32'(bus.fault_src), 32'b100);
    check("trip_cnt_rate", 32'(bus.cnt_rate_low), 32'd1);
    for (int i = 0; i < 50; i++) begin
      step();
      check("sticky_state", 32'(bus.state_o), 32'd2);
    end

    // Clear: clear_fail high exactly CLEAR_CYCLES cycles
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    check("clr_strobe0", 32'(bus.clear_fail), 32'd1);
    for (int i = 1; i < CLEAR_CYCLES; i++) begin
      step();
      check("clr_strobe", 32'(bus.clear_fail), 32'd1);
    end
    step();
    check("clr_done", 32'(bus.clear_fail), 32'd0);
    check("holdoff_state", 32'(bus.state_o), 32'd4);

    // Holdoff with a fail blip: IDLE only after HOLDOFF_CYCLES quiet cycles
    repeat (3) step();
    set_fails(1'b0, 1'b0, 1'b1);
    step();
    set_fails(1'b0, 1'b0, 1'b0);
    for (int i = 1; i < HOLDOFF_CYCLES; i++) begin
      step();
      check("holdoff_hold", 32'(bus.state_o), 32'd4);
    end
    step();
    check("holdoff_exit", 32'(bus.state_o), 32'd0);
    check("holdoff_src", 32'(bus.fault_src), 32'd0);
    check("holdoff_latched", 32'(bus.fault_latched), 32'd0);
    step();
    check("rearm_state", 32'(bus.state_o), 32'd1);

    // Simultaneous width-low and width-high
    set_fails(1'b0, 1'b1, 1'b1);
    step();
    set_fails(1'b0, 1'b0, 1'b0);
    check("dual_src", 32'(bus.fault_src), 32'b011);
    check("dual_cnt_wl", 32'(bus.cnt_width_low), 32'd2);
    check("dual_cnt_wh", 32'(bus.cnt_width_high), 32'd1);

    // Counter saturation and clear
    for (int i = 0; i < 5; i++) begin
      set_fails(1'b0, 1'b1, 1'b0); step();
      set_fails(1'b0, 1'b0, 1'b0); step();
    end
    check("sat_wh", 32'(bus.cnt_width_high), 32'd3);
    bus.cnt_clr = 1'b1;
    step();
    check("clr_wh", 32'(bus.cnt_width_high), 32'd0);
    check("clr_rl", 32'(bus.cnt_rate_low), 32'd0);
    set_fails(1'b0, 1'b1, 1'b0);
    step();
    bus.cnt_clr = 1'b0;
    check("clr_edge_wh", 32'(bus.cnt_width_high), 32'd0);
    step();
    set_fails(1'b0, 1'b0, 1'b0);
    check("held_no_edge", 32'(bus.cnt_width_high), 32'd0);

    // Reset in the middle of CLEARING
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    step();
    check("mid_clr_state", 32'(bus.state_o), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clr_fail", 32'(bus.clear_fail), 32'd0);
    check("rst_clr_state", 32'(bus.state_o), 32'd0);
    check("rst_clr_latched", 32'(bus.fault_latched), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(199) == 0);
      bus.arm         = ($urandom_range(99) < 85);
      bus.laser_ready = ($urandom_range(99) < 92);
      bus.clear_req   = ($urandom_range(99) < 15);
      bus.cnt_clr     = ($urandom_range(99) < 2);
      set_fails($urandom_range(99) < 3, $urandom_range(99) < 3, $urandom_range(99) < 3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
